// File: rtl/sv_alu_pkg.sv
// sv_alu_pkg: opcode and FSM state encodings shared by the ALU pipeline.
package sv_alu_pkg;
   typedef enum logic [3:0] {
      OP_PASSA, OP_PASSB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOTA,
      OP_ADC, OP_SBB, OP_SHL, OP_SHR, OP_SRA, OP_MUL, OP_ILL_E, OP_ILL_F
   } alu_op_e;
   typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DONE} alu_state_e;
endpackage

// File: rtl/sv_alu_mul_seq.sv
// sv_alu_mul_seq: shift-add multiplier, one partial product per cycle.
// The start edge already performs the first iteration; done is high for one cycle after the last.
module sv_alu_mul_seq #(parameter int WIDTH = 8) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   localparam int CW = $clog2(WIDTH) + 1;
   logic [WIDTH-1:0]   a_r, m_src;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] p_src, p_nx;
   logic [WIDTH:0]     acc;
   // upper half accumulates, lower half holds the remaining multiplier bits
   assign p_src = start ? {{WIDTH{1'b0}}, b} : product;
   assign m_src = start ? a : a_r;
   assign acc   = {1'b0, p_src[2*WIDTH-1:WIDTH]} + {1'b0, (p_src[0] ? m_src : {WIDTH{1'b0}})};
   assign p_nx  = {acc, p_src[WIDTH-1:1]};
   assign done  = cnt == CW'(WIDTH);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt     <= '0;
         a_r     <= '0;
         product <= '0;
      end else if (start) begin
         cnt     <= CW'(1);
         a_r     <= a;
         product <= p_nx;
      end else if (done) begin
         cnt     <= '0;
      end else if (cnt != '0) begin
         cnt     <= cnt + 1'b1;
         product <= p_nx;
      end
endmodule

// File: rtl/sv_alu_pipe.sv
// sv_alu_pipe: handshaked ALU with registered result/flags and a sequential multiplier.
module sv_alu_pipe
   import sv_alu_pkg::*;
#(parameter int WIDTH = 8) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic             err,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);
   alu_state_e state, state_nx;
   logic accept, is_mul, mul_done, mul_fin, load, c_reg;
   logic carry_c, ovf_c, err_c, ld_carry;
   logic [WIDTH-1:0] res_c, ld_res;
   logic [WIDTH:0] sum, dif;
   logic [SHW-1:0] sh;
   logic [2*WIDTH-1:0] product;
   assign in_ready  = state == S_IDLE || (state == S_DONE && out_ready);
   assign out_valid = state == S_DONE;
   assign busy      = state == S_MUL_RUN;
   assign accept    = in_valid && in_ready;
   assign is_mul    = op == OP_MUL;
   assign sh        = b[SHW-1:0];
   assign sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c_reg && op == OP_ADC);
   assign dif = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(c_reg && op == OP_SBB);
   sv_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk(clk), .rst_n(rst_n), .start(accept && is_mul),
      .a(a), .b(b), .done(mul_done), .product(product)
   );
   // right shifts carry a guard bit below the LSB so the last bit out lands in bit 0
   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      err_c   = 1'b0;
      case (alu_op_e'(op))
         OP_PASSA: res_c = a;
         OP_PASSB: res_c = b;
         OP_ADD, OP_ADC: begin
            {carry_c, res_c} = sum;
            ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_SBB: begin
            {carry_c, res_c} = dif;
            ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  res_c = a & b;
         OP_OR:   res_c = a | b;
         OP_XOR:  res_c = a ^ b;
         OP_NOTA: res_c = ~a;
         OP_SHL:  {carry_c, res_c} = {1'b0, a} << sh;
         OP_SHR:  {res_c, carry_c} = {a, 1'b0} >> sh;
         OP_SRA:  {res_c, carry_c} = $signed({a, 1'b0}) >>> sh;
         OP_MUL:  res_c = '0;
         default: err_c = 1'b1;
      endcase
   end
   assign mul_fin  = state == S_MUL_RUN && mul_done;
   assign load     = (accept && !is_mul) || mul_fin;
   assign ld_res   = mul_fin ? product[WIDTH-1:0] : res_c;
   assign ld_carry = mul_fin ? |product[2*WIDTH-1:WIDTH] : carry_c;
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (accept) state_nx = is_mul ? S_MUL_RUN : S_DONE;
         S_MUL_RUN: if (mul_done) state_nx = S_DONE;
         S_DONE:    if (out_ready) state_nx = accept ? (is_mul ? S_MUL_RUN : S_DONE) : S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= S_IDLE;
         result   <= '0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         negative <= 1'b0;
         overflow <= 1'b0;
         err      <= 1'b0;
         c_reg    <= 1'b0;
      end else begin
         state <= state_nx;
         if (load) begin
            result   <= ld_res;
            zero     <= ld_res == '0 && !(err_c && !mul_fin);
            carry    <= ld_carry;
            negative <= ld_res[WIDTH-1];
            overflow <= ovf_c && !mul_fin;
            err      <= err_c && !mul_fin;
            c_reg    <= ld_carry;
         end
      end
endmodule

// File: tb/tb_sv_alu_pipe.sv
// tb_sv_alu_pipe: scoreboard bench with an arithmetic reference model, WIDTH=8.
module tb_sv_alu_pipe;
   logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 1;
   logic in_ready, out_valid, zero, carry, negative, overflow, err, busy;
   logic [7:0] a = 0, b = 0, result;
   logic [3:0] op = 0;
   int total = 0, bad = 0, mc = 0;
   bit rnd_ready = 0;
   logic [12:0] q[$];

   sv_alu_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .carry(carry), .negative(negative),
      .overflow(overflow), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // packed as {result[7:0], zero, carry, negative, overflow, err}
   function automatic logic [12:0] model(input int o, input int x, input int y);
      int t, sx, sy, st, sh, r, ci;
      logic c, v, e;
      sx = (x > 127) ? x - 256 : x;
      sy = (y > 127) ? y - 256 : y;
      sh = y % 8;
      ci = (o == 8 || o == 9) ? mc : 0;
      c = 0; v = 0; e = 0; r = 0; t = 0; st = 0;
      case (o)
         0: r = x;
         1: r = y;
         2, 8: begin t = x + y + ci; st = sx + sy + ci; r = t; c = t > 255; v = st > 127 || st < -128; end
         3, 9: begin t = x - y - ci; st = sx - sy - ci; r = t; c = t < 0; v = st > 127 || st < -128; end
         4: r = x & y;
         5: r = x | y;
         6: r = x ^ y;
         7: r = ~x;
         10: begin r = x << sh; c = sh != 0 && ((x >> (8 - sh)) & 1) != 0; end
         11: begin r = x >> sh; c = sh != 0 && ((x >> (sh - 1)) & 1) != 0; end
         12: begin r = sx >>> sh; c = sh != 0 && ((x >> (sh - 1)) & 1) != 0; end
         13: begin t = x * y; r = t; c = t > 255; end
         default: e = 1;
      endcase
      r = r & 255;
      return {r[7:0], r == 0 && !e, c, r[7], v, e};
   endfunction

   // called just after a rising edge; returns just after the accepting edge
   task automatic send(input int o, input int x, input int y, output int waits);
      logic [12:0] e;
      waits = 0;
      in_valid = 1; op = 4'(o); a = 8'(x); b = 8'(y);
      @(negedge clk);
      while (!in_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL accept timeout: op=%0d in_ready=%0b expected 1", o, in_ready);
      end else begin
         e = model(o, x, y);
         mc = int'(e[3]);
         q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain queue empty", 64'(q.size()), 64'(0));
      @(posedge clk); #1;
   endtask

   initial forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected out_valid: result=%0h expected no output", result);
         end else begin
            chk("result+flags", 64'({result, zero, carry, negative, overflow, err}), 64'(q[0]));
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = $urandom_range(0, 3) != 0;
   end

   initial begin
      int w;
      #2 rst_n = 0;
      @(negedge clk);
      chk("reset handshake", 64'({out_valid, in_ready, busy}), 64'(3'b010));
      chk("reset outputs", 64'({result, zero, carry, negative, overflow, err}), 64'(0));
      @(posedge clk); #1 rst_n = 1;
      send(2, 'hFF, 'h01, w);
      chk("accept right after reset", 64'(w), 64'(0));
      send(8, 'h10, 'h20, w);
      send(3, 'h80, 'h01, w);
      send(3, 'h05, 'h06, w);
      drain();
      send(13, 'h10, 'h11, w);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("mul busy/in_ready/out_valid", 64'({busy, in_ready, out_valid}), 64'(3'b100));
      end
      @(negedge clk);
      chk("mul done busy/out_valid", 64'({busy, out_valid}), 64'(2'b01));
      @(posedge clk); #1;
      drain();
      out_ready = 0;
      send(6, 'h5A, 'h3C, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold out_valid/in_ready", 64'({out_valid, in_ready}), 64'(2'b10));
      end
      @(posedge clk); #1;
      out_ready = 1;
      send(0, 'h77, 'h00, w);
      chk("accept on out_ready rise", 64'(w), 64'(0));
      drain();
      send(2, 'hFF, 'h01, w);
      drain();
      send(13, 'h12, 'h34, w);
      repeat (3) @(negedge clk);
      @(posedge clk); #2;
      rst_n = 0;
      q.delete();
      mc = 0;
      @(negedge clk);
      chk("reset mid-mul", 64'({out_valid, busy, in_ready}), 64'(3'b001));
      @(posedge clk); #1 rst_n = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("no output after reset", 64'(out_valid), 64'(0));
      end
      @(posedge clk); #1;
      send(8, 'h00, 'h00, w);
      send(10, 'h81, 'h01, w);
      send(14, 'h00, 'h00, w);
      send(0, 'h00, 'h00, w);
      drain();
      rnd_ready = 1;
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         send(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), w);
      end
      rnd_ready = 0;
      out_ready = 1;
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sv_alu_pipe.md
SV_ALU_PIPE -- requirements
Module: sv_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal values are powers of two, 4 to 64.
REQ-002 SHALL have localparam SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1, the operand-side handshake.
REQ-006 SHALL have ports a input WIDTH, b input WIDTH, op input 4, the operands and opcode, sampled on accept.
REQ-007 SHALL have ports out_valid output 1 / out_ready input 1, the result-side handshake.
REQ-008 SHALL have port result output WIDTH.
REQ-009 SHALL have flag ports zero, carry, negative, overflow and err, each output 1 bit.
REQ-010 SHALL have port busy output 1, high while a multi-cycle operation iterates.

Function
REQ-011 Accept SHALL occur on an edge where in_valid and in_ready are both high; a, b and op are captured on that edge.
REQ-012 Opcodes SHALL be:
- 0 PASSA, 1 PASSB, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOTA.
- 8 ADC = a+b+c_reg; 9 SBB = a-b-c_reg.
- A SHL, B SHR logical, C SRA, each by b[SHW-1:0].
- D MUL, low WIDTH bits of the product.
- E and F illegal.
REQ-013 Arithmetic SHALL be performed at WIDTH+1 bits. carry = bit WIDTH for ADD/ADC, and the borrow for SUB/SBB.
REQ-014 For shifts, carry SHALL be the last bit shifted out, and 0 for a shift amount of 0.
REQ-015 For MUL, carry SHALL be 1 when the upper WIDTH product bits are non-zero.
REQ-016 For logic and pass ops, carry SHALL be 0.
REQ-017 overflow SHALL be the two's-complement signed overflow for ADD/SUB/ADC/SBB, and 0 for all other ops.
REQ-018 negative SHALL equal result[WIDTH-1]; zero SHALL equal (result == 0).
REQ-019 For an illegal opcode: result = 0, err = 1, and zero/carry/negative/overflow = 0; every other op drives err = 0.
REQ-020 Register c_reg SHALL load the carry of each completed op, including MUL, shifts and illegal ops, on the edge the result is registered; ADC/SBB read c_reg as it stands at accept.
REQ-021 The FSM SHALL have states IDLE, MUL_RUN and DONE.
REQ-022 FSM transitions:
- IDLE -> DONE on accept of any non-MUL op.
- IDLE -> MUL_RUN on accept of MUL.
- MUL_RUN -> DONE after exactly WIDTH shift-add iterations.
- DONE -> IDLE on out_ready with no new accept.
- DONE -> DONE or MUL_RUN on out_ready with a simultaneous accept.
REQ-023 Latency SHALL be: out_valid rises 1 cycle after accept for non-MUL ops, and WIDTH+1 cycles after accept for MUL.
REQ-024 in_ready SHALL be high in IDLE, low in MUL_RUN, and equal to out_ready in DONE, so one op per cycle is sustained.
REQ-025 out_valid SHALL be high only in DONE; result and all flags SHALL hold stable while out_valid && !out_ready.
REQ-026 busy SHALL be high exactly in MUL_RUN.
REQ-027 Outputs SHALL be registered; there is no combinational path from a, b or op to result or the flags.

Reset
REQ-028 While rst_n is low, the block SHALL hold: state = IDLE, out_valid = 0, in_ready = 1 (after reset), busy = 0, result = 0, all flags = 0, c_reg = 0.
REQ-029 Reset asserted mid-MUL or in DONE SHALL discard the operation without emitting a result.
REQ-030 Reset deassertion SHALL require no warm-up cycle; the first edge after release can accept.

Structure
REQ-031 Package sv_alu_pkg SHALL hold enum alu_op_e (4-bit opcodes) and enum alu_state_e.
REQ-032 The shift-add multiplier SHALL be sub-module sv_alu_mul_seq (start, a, b -> done, product of width 2*WIDTH), instantiated once.
REQ-033 All single-cycle ops SHALL be computed in one always_comb block feeding the output registers.

Verification (WIDTH=8)
REQ-034 ADD a=FF, b=01 -> next cycle result=00, zero=1, carry=1, overflow=0; then ADC a=10, b=20 -> result=31, carry=0.
REQ-035 SUB a=80, b=01 -> result=7F, overflow=1, carry=0; SUB a=05, b=06 -> result=FF, carry=1, negative=1.
REQ-036 MUL a=10, b=11 -> in_ready=0 and busy=1 for 8 cycles; out_valid at cycle 9 with result=10, carry=1.
REQ-037 Hold out_ready=0 for 3 cycles on an XOR result -> result and flags stable, in_ready=0; on raising out_ready, a new op is accepted the same edge.
REQ-038 Assert rst_n=0 in MUL cycle 4 -> out_valid stays 0, c_reg=0; after release, SHL a=81, b=01 -> result=02, carry=1.
REQ-039 op=E -> result=00, err=1, zero=0; a following PASSA a=00 -> err=0, zero=1.
